// File: rtl/ex_stage.sv
// RV32I execute stage: ALU, address generation, branch/jump resolution and an
// iterative shifter, registered into the EX/MEM output register on the falling clock edge.
module ex_stage #(
   parameter int unsigned SHIFT_STEP = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic        flush,
   input  logic [31:0] pc,
   input  logic [2:0]  inst_type,
   input  logic [2:0]  funct3,
   input  logic [5:0]  funct7,
   input  logic [31:0] imm,
   input  logic [31:0] val_rs,
   input  logic [31:0] val_rs2,
   input  logic [4:0]  rd,
   input  logic [6:0]  opcode,
   output logic        stall,
   output logic        out_valid,
   output logic [31:0] ex_result,
   output logic [31:0] ex_store_data,
   output logic [4:0]  ex_rd,
   output logic [6:0]  ex_opcode,
   output logic [2:0]  ex_funct3,
   output logic        branch_taken,
   output logic [31:0] branch_target
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [4:0] STEP_AMT  = 5'(SHIFT_STEP);

   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   state_t      state, state_n;
   logic [4:0]  remaining, rem_n;
   logic [31:0] shreg, shreg_n;
   logic        left_q, left_n, arith_q, arith_n;

   logic        valid_n, taken_n;
   logic [31:0] result_n, store_n, target_n;
   logic [4:0]  rd_n;
   logic [6:0]  opc_n;
   logic [2:0]  f3_n;

   logic        is_r, is_alu, is_shift, sh_left, sh_arith, long_shift;
   logic [31:0] op2, alu_res, jalr_sum;
   logic [4:0]  shamt, step_amt;
   logic        br_cond, known, inst_taken;
   logic [31:0] inst_res, inst_target, stepped;

   logic unused_bits;
   assign unused_bits = ^{inst_type, funct7[4:0]};

   function automatic logic [31:0] shift_by(input logic [31:0] v, input logic [4:0] amt,
                                            input logic left, input logic arith);
      if (left)       return v << amt;
      else if (arith) return $unsigned($signed(v) >>> amt);
      else            return v >> amt;
   endfunction

   assign is_r       = (opcode == OP_R);
   assign is_alu     = is_r || (opcode == OP_I);
   assign op2        = is_r ? val_rs2 : imm;
   assign shamt      = op2[4:0];
   assign is_shift   = is_alu && (funct3[1:0] == 2'b01);
   assign sh_left    = ~funct3[2];
   assign sh_arith   = funct3[2] & funct7[5];
   assign long_shift = is_shift && (shamt > STEP_AMT);
   assign jalr_sum   = val_rs + imm;

   always_comb begin
      alu_res = '0;
      case (funct3)
         3'b000:          alu_res = (is_r && funct7[5]) ? val_rs - op2 : val_rs + op2;
         3'b001, 3'b101:  alu_res = shift_by(val_rs, shamt, sh_left, sh_arith);
         3'b010:          alu_res = {31'b0, $signed(val_rs) < $signed(op2)};
         3'b011:          alu_res = {31'b0, val_rs < op2};
         3'b100:          alu_res = val_rs ^ op2;
         3'b110:          alu_res = val_rs | op2;
         default:         alu_res = val_rs & op2;
      endcase
   end

   always_comb begin
      case (funct3)
         3'b000:  br_cond = (val_rs == val_rs2);
         3'b001:  br_cond = (val_rs != val_rs2);
         3'b100:  br_cond = ($signed(val_rs) < $signed(val_rs2));
         3'b101:  br_cond = ($signed(val_rs) >= $signed(val_rs2));
         3'b110:  br_cond = (val_rs < val_rs2);
         3'b111:  br_cond = (val_rs >= val_rs2);
         default: br_cond = 1'b0;
      endcase
   end

   always_comb begin
      known       = 1'b1;
      inst_res    = '0;
      inst_taken  = 1'b0;
      inst_target = pc + imm;
      case (opcode)
         OP_R, OP_I:          inst_res = alu_res;
         OP_LOAD, OP_STORE:   inst_res = val_rs + imm;
         OP_BRANCH:           inst_taken = br_cond;
         OP_JAL: begin
            inst_res   = pc + 32'd4;
            inst_taken = 1'b1;
         end
         OP_JALR: begin
            inst_res    = pc + 32'd4;
            inst_taken  = 1'b1;
            inst_target = {jalr_sum[31:1], 1'b0};
         end
         OP_LUI:              inst_res = imm;
         OP_AUIPC:            inst_res = pc + imm;
         default:             known = 1'b0;
      endcase
   end

   assign stall = rst_n & in_valid & ~flush & is_shift &
                  ((state == S_IDLE) ? (shamt > STEP_AMT) : (remaining > STEP_AMT));

   // The final shift step may be shorter than SHIFT_STEP when shamt is not a multiple of it.
   assign step_amt = (remaining < STEP_AMT) ? remaining : STEP_AMT;
   assign stepped  = shift_by(shreg, step_amt, left_q, arith_q);

   always_comb begin
      state_n  = state;
      rem_n    = remaining;
      shreg_n  = shreg;
      left_n   = left_q;
      arith_n  = arith_q;
      valid_n  = out_valid;
      taken_n  = branch_taken;
      result_n = ex_result;
      store_n  = ex_store_data;
      target_n = branch_target;
      rd_n     = ex_rd;
      opc_n    = ex_opcode;
      f3_n     = ex_funct3;
      if (flush) begin
         valid_n = 1'b0;
         taken_n = 1'b0;
         state_n = S_IDLE;
         rem_n   = '0;
      end else if (state == S_SHIFT) begin
         taken_n = 1'b0;
         if (remaining <= STEP_AMT) begin
            valid_n  = 1'b1;
            result_n = stepped;
            state_n  = S_IDLE;
            rem_n    = '0;
         end else begin
            valid_n = 1'b0;
            shreg_n = stepped;
            rem_n   = remaining - STEP_AMT;
         end
      end else if (!in_valid || !known) begin
         valid_n = 1'b0;
         taken_n = 1'b0;
      end else begin
         // Destination fields are captured at acceptance so a long shift need not track them.
         rd_n    = rd;
         opc_n   = opcode;
         f3_n    = funct3;
         store_n = val_rs2;
         if (long_shift) begin
            valid_n = 1'b0;
            taken_n = 1'b0;
            state_n = S_SHIFT;
            shreg_n = shift_by(val_rs, STEP_AMT, sh_left, sh_arith);
            rem_n   = shamt - STEP_AMT;
            left_n  = sh_left;
            arith_n = sh_arith;
         end else begin
            valid_n  = 1'b1;
            result_n = inst_res;
            taken_n  = inst_taken;
            target_n = inst_target;
         end
      end
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         remaining     <= '0;
         shreg         <= '0;
         left_q        <= 1'b0;
         arith_q       <= 1'b0;
         out_valid     <= 1'b0;
         branch_taken  <= 1'b0;
         ex_result     <= '0;
         ex_store_data <= '0;
         branch_target <= '0;
         ex_rd         <= '0;
         ex_opcode     <= '0;
         ex_funct3     <= '0;
      end else begin
         state         <= state_n;
         remaining     <= rem_n;
         shreg         <= shreg_n;
         left_q        <= left_n;
         arith_q       <= arith_n;
         out_valid     <= valid_n;
         branch_taken  <= taken_n;
         ex_result     <= result_n;
         ex_store_data <= store_n;
         branch_target <= target_n;
         ex_rd         <= rd_n;
         ex_opcode     <= opc_n;
         ex_funct3     <= f3_n;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: a driver issues instructions and queues the reference
// model's expected EX/MEM entry; a monitor pops and compares whenever out_valid is seen.
module tb_ex_stage;

   localparam int STEP = 4;

   logic        clk = 1'b1, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0;
   logic [31:0] pc = '0, imm = '0, val_rs = '0, val_rs2 = '0;
   logic [2:0]  inst_type = '0, funct3 = '0;
   logic [5:0]  funct7 = '0;
   logic [4:0]  rd = '0;
   logic [6:0]  opcode = '0;
   logic        stall, out_valid, branch_taken;
   logic [31:0] ex_result, ex_store_data, branch_target;
   logic [4:0]  ex_rd;
   logic [6:0]  ex_opcode;
   logic [2:0]  ex_funct3;

   ex_stage #(.SHIFT_STEP(STEP)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .flush(flush), .pc(pc),
      .inst_type(inst_type), .funct3(funct3), .funct7(funct7), .imm(imm),
      .val_rs(val_rs), .val_rs2(val_rs2), .rd(rd), .opcode(opcode), .stall(stall),
      .out_valid(out_valid), .ex_result(ex_result), .ex_store_data(ex_store_data),
      .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
      .branch_taken(branch_taken), .branch_target(branch_target)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0, edge_n = 0;
   always @(negedge clk) edge_n <= edge_n + 1;

   typedef struct {
      logic [31:0] res, tgt, store;
      logic [4:0]  rd;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic        tk, is_store;
      int          edge_no;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic        ok, tk, is_shift;
      logic [31:0] res, tgt;
      int          shamt;
   } m_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic m_t model(input logic [6:0] opc, input logic [2:0] f3, input logic f7b5,
                                input logic [31:0] p, input logic [31:0] im,
                                input logic [31:0] a, input logic [31:0] b);
      m_t m;
      logic [31:0] o2;
      int sh;
      m.ok = 1'b1; m.tk = 1'b0; m.is_shift = 1'b0; m.res = '0; m.tgt = p + im; m.shamt = 0;
      case (opc)
         7'h33, 7'h13: begin
            o2 = (opc == 7'h33) ? b : im;
            sh = int'(o2[4:0]);
            case (f3)
               3'd0: m.res = (opc == 7'h33 && f7b5) ? a - o2 : a + o2;
               3'd1: begin m.res = a << sh; m.is_shift = 1'b1; m.shamt = sh; end
               3'd2: m.res = ($signed(a) < $signed(o2)) ? 32'd1 : 32'd0;
               3'd3: m.res = (a < o2) ? 32'd1 : 32'd0;
               3'd4: m.res = a ^ o2;
               3'd5: begin
                  m.res = f7b5 ? $unsigned($signed(a) >>> sh) : a >> sh;
                  m.is_shift = 1'b1; m.shamt = sh;
               end
               3'd6: m.res = a | o2;
               default: m.res = a & o2;
            endcase
         end
         7'h03, 7'h23: m.res = a + im;
         7'h63: case (f3)
            3'd0: m.tk = (a == b);
            3'd1: m.tk = (a != b);
            3'd4: m.tk = ($signed(a) < $signed(b));
            3'd5: m.tk = ($signed(a) >= $signed(b));
            3'd6: m.tk = (a < b);
            3'd7: m.tk = (a >= b);
            default: m.tk = 1'b0;
         endcase
         7'h6F: begin m.res = p + 32'd4; m.tk = 1'b1; end
         7'h67: begin m.res = p + 32'd4; m.tk = 1'b1; m.tgt = (a + im) & 32'hFFFF_FFFE; end
         7'h37: m.res = im;
         7'h17: m.res = p + im;
         default: m.ok = 1'b0;
      endcase
      return m;
   endfunction

   function automatic logic [2:0] itype(input logic [6:0] opc);
      case (opc)
         7'h33: return 3'd0;
         7'h23: return 3'd2;
         7'h63: return 3'd3;
         7'h37, 7'h17: return 3'd4;
         7'h6F: return 3'd5;
         default: return 3'd1;
      endcase
   endfunction

   // flush_at = k asserts flush before the k-th edge of the instruction (0 = never).
   task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [5:0] f7,
                        input logic [31:0] p, input logic [31:0] im, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] d, input int flush_at);
      m_t m;
      exp_t e;
      int n;
      @(posedge clk);
      opcode = opc; funct3 = f3; funct7 = f7; pc = p; imm = im; val_rs = a; val_rs2 = b;
      rd = d; inst_type = itype(opc); in_valid = 1'b1; flush = 1'b0;
      m = model(opc, f3, f7[5], p, im, a, b);
      n = (m.is_shift && m.shamt > STEP) ? (m.shamt + STEP - 1) / STEP : 1;
      if (m.ok && (flush_at == 0 || flush_at > n)) begin
         e.res = m.res; e.tgt = m.tgt; e.store = b; e.rd = d; e.opc = opc; e.f3 = f3;
         e.tk = m.tk; e.is_store = (opc == 7'h23); e.edge_no = edge_n + n;
         sb.push_back(e);
      end
      for (int k = 1; k <= n; k++) begin
         if (k == flush_at) flush = 1'b1;
         #1;
         chk("stall", {31'b0, stall}, (k < n && !flush) ? 32'd1 : 32'd0);
         @(negedge clk);
         if (flush) break;
         if (k < n) @(posedge clk);
      end
   endtask

   task automatic bubble();
      @(posedge clk);
      in_valid = 1'b0; flush = 1'b0; opcode = 7'h33; funct3 = 3'd1; val_rs2 = 32'd31;
      #1;
      chk("stall_bubble", {31'b0, stall}, 32'd0);
      @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
      chk({tag, "_result"}, ex_result, 32'd0);
      chk({tag, "_store"}, ex_store_data, 32'd0);
      chk({tag, "_rd"}, {27'b0, ex_rd}, 32'd0);
      chk({tag, "_opcode"}, {25'b0, ex_opcode}, 32'd0);
      chk({tag, "_funct3"}, {29'b0, ex_funct3}, 32'd0);
      chk({tag, "_taken"}, {31'b0, branch_taken}, 32'd0);
      chk({tag, "_target"}, branch_target, 32'd0);
      chk({tag, "_stall"}, {31'b0, stall}, 32'd0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (out_valid) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_valid: got out_valid=1 result=%h expected no pending entry", ex_result);
            end else begin
               e = sb.pop_front();
               chk("edge", 32'(edge_n), 32'(e.edge_no));
               chk("result", ex_result, e.res);
               chk("rd", {27'b0, ex_rd}, {27'b0, e.rd});
               chk("opcode", {25'b0, ex_opcode}, {25'b0, e.opc});
               chk("funct3", {29'b0, ex_funct3}, {29'b0, e.f3});
               chk("taken", {31'b0, branch_taken}, {31'b0, e.tk});
               if (e.tk) chk("target", branch_target, e.tgt);
               if (e.is_store) chk("store_data", ex_store_data, e.store);
            end
         end else begin
            chk("taken_without_valid", {31'b0, branch_taken}, 32'd0);
         end
      end
   end

   logic [6:0] ops [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F, 7'h00};

   initial begin : driver
      logic [31:0] a, b, im;
      #12;
      chk_all_zero("reset");
      @(posedge clk);
      rst_n = 1'b1;

      issue(7'h33, 3'd0, 6'h00, 32'h0, 32'h0, 32'h7FFF_FFFF, 32'd1, 5'd5, 0);
      issue(7'h33, 3'd0, 6'h20, 32'h0, 32'h0, 32'd3, 32'd5, 5'd6, 0);
      issue(7'h33, 3'd5, 6'h20, 32'h0, 32'h0, 32'h8000_0000, 32'd5, 5'd7, 0);
      issue(7'h13, 3'd5, 6'h00, 32'h0, 32'h0, 32'h1234_5678, 32'd9, 5'd8, 0);
      issue(7'h13, 3'd5, 6'h20, 32'h0, 32'd3, 32'h9000_0000, 32'd0, 5'd9, 0);
      issue(7'h63, 3'd4, 6'h00, 32'h100, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'd0, 5'd0, 0);
      issue(7'h63, 3'd7, 6'h00, 32'h100, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'd0, 5'd0, 0);
      issue(7'h67, 3'd0, 6'h00, 32'h40, 32'd2, 32'h1003, 32'd0, 5'd1, 0);
      issue(7'h33, 3'd1, 6'h00, 32'h0, 32'h0, 32'h1, 32'd20, 5'd10, 3);
      issue(7'h33, 3'd0, 6'h00, 32'h0, 32'h0, 32'd10, 32'd20, 5'd11, 0);
      issue(7'h33, 3'd1, 6'h00, 32'h0, 32'h0, 32'h0000_0003, 32'd17, 5'd12, 0);
      issue(7'h33, 3'd5, 6'h00, 32'h0, 32'h0, 32'h8000_0000, 32'd31, 5'd13, 0);
      issue(7'h23, 3'd2, 6'h00, 32'h0, 32'h10, 32'h2000, 32'hDEAD_BEEF, 5'd0, 0);
      issue(7'h7F, 3'd0, 6'h00, 32'h0, 32'h0, 32'd1, 32'd1, 5'd3, 0);
      bubble();

      // Reset during a long shift: outputs (nonzero after the JAL) clear at once, no pulse later.
      issue(7'h6F, 3'd0, 6'h00, 32'h200, 32'h40, 32'h0, 32'h0, 5'd1, 0);
      @(posedge clk);
      opcode = 7'h33; funct3 = 3'd1; funct7 = 6'h00; val_rs = 32'h1; val_rs2 = 32'd20;
      rd = 5'd2; in_valid = 1'b1; flush = 1'b0;
      @(negedge clk); @(posedge clk); @(negedge clk); @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("midshift_reset");
      in_valid = 1'b0;
      @(posedge clk);
      rst_n = 1'b1;
      issue(7'h33, 3'd0, 6'h00, 32'h0, 32'h0, 32'd100, 32'd23, 5'd4, 0);

      for (int i = 0; i < 250; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            bubble();
         end else begin
            a  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            b  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 31)) : $urandom;
            im = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom;
            issue(ops[$urandom_range(0, 10)], 3'($urandom), 6'($urandom), $urandom, im, a, b,
                  5'($urandom), ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0);
         end
      end
      bubble();
      bubble();
      chk("pending_entries", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
